// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and address alignment helper.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } ahb_state_e;

  function automatic logic [31:0] ahb_align(
    input logic [31:0] addr,
    input logic [2:0]  size
  );
    logic [31:0] a;
    a = addr;
    unique case (1'b1)
      (size == HSIZE_HALF): a[0]   = 1'b0;
      (size == HSIZE_WORD): a[1:0] = 2'b00;
      default: ;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ahblite_lane_steer.sv
// Byte-lane steering: write-data replication and read-lane extraction
// from transfer size and the low address bits.
module ahblite_lane_steer
  import ahb_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  sh_amt;
  logic [31:0] rd_sh;

  assign sh_amt = {addr_i, 3'b000};
  assign rd_sh  = rdata_i >> sh_amt;

  always_comb begin
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    unique case (1'b1)
      (size_i == HSIZE_BYTE): begin
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = rd_sh & 32'h0000_00FF;
      end
      (size_i == HSIZE_HALF): begin
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = rd_sh & 32'h0000_FFFF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahblite_master.sv
// Single-outstanding AHB-Lite initiator; all bus outputs registered.
// Define AHBLITE_MASTER_TIMEOUT_EN to enable the data-phase wait-state timeout.
module ahblite_master
  import ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  ahb_state_e  state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [2:0]  hsize_q, hsize_d;
  logic        hwrite_q, hwrite_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        ready_q, ready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;
  logic        rto_q, rto_d;
  logic [2:0]  size_n;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic        stall;
  logic        tmo;

  assign size_n = (cmd_size == 2'd3) ? HSIZE_WORD : {1'b0, cmd_size};
  assign stall  = ((state_q == ST_DATA) || (state_q == ST_ERR)) && !HREADY;

  ahblite_lane_steer u_steer (
    .size_i  (hsize_q),
    .addr_i  (haddr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (HRDATA),
    .wdata_o (wdata_rep),
    .rdata_o (rdata_ext)
  );

`ifdef AHBLITE_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;

  assign tmo = stall && (cnt_q == TMO_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (stall)         cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    htrans_d = htrans_q;
    wdata_d  = wdata_q;
    hwdata_d = hwdata_q;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    rerr_d   = 1'b0;
    rto_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d  = ST_ADDR;
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = cmd_write;
          hsize_d  = size_n;
          haddr_d  = ahb_align(cmd_addr, size_n);
          wdata_d  = cmd_wdata;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) hwdata_d = wdata_rep;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b1;
          rerr_d   = (HRESP == HRESP_ERROR);
          if (!hwrite_q && (HRESP == HRESP_OKAY)) rdata_d = rdata_ext;
        end else if (HRESP == HRESP_ERROR) begin
          state_d = ST_ERR;
        end else if (tmo) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
          rto_d    = 1'b1;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
        end else if (tmo) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
          rto_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      haddr_q  <= '0;
      hsize_q  <= HSIZE_BYTE;
      hwrite_q <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      wdata_q  <= '0;
      hwdata_q <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      htrans_q <= htrans_d;
      wdata_q  <= wdata_d;
      hwdata_q <= hwdata_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      rto_q    <= rto_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign rsp_valid   = rvalid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rerr_q;
  assign rsp_timeout = rto_q;
  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = HBURST_SINGLE;
  assign HPROT       = HPROT_VAL;
  assign HMASTLOCK   = 1'b0;
  assign HWRITE      = hwrite_q;
  assign HWDATA      = hwdata_q;

endmodule

// File: tb/tb_ahblite_master.sv
// Directed self-checking bench for ahblite_master.
// Define AHBLITE_MASTER_TIMEOUT_EN to also exercise the timeout abort.
module tb_ahblite_master;

`ifdef AHBLITE_MASTER_TIMEOUT_EN
  localparam int unsigned TO_CYC = 4;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  int checks;
  int failures;

  ahblite_master #(
    .TIMEOUT_CYCLES (TO_CYC),
    .HPROT_VAL      (4'b0011)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_size    (cmd_size),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HPROT       (HPROT),
    .HMASTLOCK   (HMASTLOCK),
    .HWRITE      (HWRITE),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic drive_cmd(input logic w, input logic [31:0] a,
                           input logic [1:0] s, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL rst_htrans got=%h exp=%h", HTRANS, 2'b00); end
    checks++; if (HADDR !== 32'h0) begin failures++; $display("FAIL rst_haddr got=%h exp=%h", HADDR, 32'h0); end
    checks++; if (HWDATA !== 32'h0) begin failures++; $display("FAIL rst_hwdata got=%h exp=%h", HWDATA, 32'h0); end
    checks++; if (HWRITE !== 1'b0) begin failures++; $display("FAIL rst_hwrite got=%h exp=0", HWRITE); end
    checks++; if (HSIZE !== 3'd0) begin failures++; $display("FAIL rst_hsize got=%h exp=0", HSIZE); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%h exp=1", cmd_ready); end
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000) begin failures++; $display("FAIL rst_rsp got=%b exp=000", {rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
    checks++; if ({HBURST, HPROT, HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin failures++; $display("FAIL rst_const got=%h exp=%h", {HBURST, HPROT, HMASTLOCK}, {3'b000, 4'b0011, 1'b0}); end
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_word_write;
    HREADY = 1'b1; HRESP = 1'b0;
    drive_cmd(1'b1, 32'h4000_0000, 2'd2, 32'h0000_1234);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    checks++; if (HTRANS !== 2'b10) begin failures++; $display("FAIL ww_htrans_a got=%h exp=%h", HTRANS, 2'b10); end
    checks++; if (HADDR !== 32'h4000_0000) begin failures++; $display("FAIL ww_haddr got=%h exp=%h", HADDR, 32'h4000_0000); end
    checks++; if ({HWRITE, HSIZE} !== {1'b1, 3'd2}) begin failures++; $display("FAIL ww_ctrl got=%h exp=%h", {HWRITE, HSIZE}, {1'b1, 3'd2}); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL ww_ready_busy got=%h exp=0", cmd_ready); end
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL ww_htrans_d got=%h exp=00", HTRANS); end
    checks++; if (HWDATA !== 32'h0000_1234) begin failures++; $display("FAIL ww_hwdata got=%h exp=%h", HWDATA, 32'h0000_1234); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL ww_rsp_early got=%h exp=0", rsp_valid); end
    @(negedge HCLK);
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin failures++; $display("FAIL ww_rsp got=%b exp=100", {rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL ww_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ww_ready got=%h exp=1", cmd_ready); end
    @(negedge HCLK);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL ww_rsp_pulse got=%h exp=0", rsp_valid); end
  endtask

  task automatic test_byte_read;
    drive_cmd(1'b0, 32'h4000_0003, 2'd0, 32'h0);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    checks++; if (HADDR !== 32'h4000_0003) begin failures++; $display("FAIL br_haddr got=%h exp=%h", HADDR, 32'h4000_0003); end
    checks++; if ({HTRANS, HSIZE, HWRITE} !== {2'b10, 3'd0, 1'b0}) begin failures++; $display("FAIL br_ctrl got=%h exp=%h", {HTRANS, HSIZE, HWRITE}, {2'b10, 3'd0, 1'b0}); end
    @(negedge HCLK);
    HREADY = 1'b0; HRDATA = 32'hAB00_0000;
    @(negedge HCLK);
    checks++; if ({rsp_valid, HTRANS} !== 3'b000) begin failures++; $display("FAIL br_wait got=%b exp=000", {rsp_valid, HTRANS}); end
    @(negedge HCLK);
    HREADY = 1'b1;
    @(negedge HCLK);
    checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin failures++; $display("FAIL br_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    checks++; if (rsp_rdata !== 32'h0000_00AB) begin failures++; $display("FAIL br_rdata got=%h exp=%h", rsp_rdata, 32'h0000_00AB); end
    HRDATA = 32'h0;
    @(negedge HCLK);
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL br_rdata_clr got=%h exp=0", rsp_rdata); end
  endtask

  task automatic test_half_write;
    drive_cmd(1'b1, 32'h4000_0003, 2'd1, 32'h0000_5678);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    checks++; if (HADDR !== 32'h4000_0002) begin failures++; $display("FAIL hw_haddr got=%h exp=%h", HADDR, 32'h4000_0002); end
    checks++; if (HSIZE !== 3'd1) begin failures++; $display("FAIL hw_hsize got=%h exp=1", HSIZE); end
    @(negedge HCLK);
    checks++; if (HWDATA !== 32'h5678_5678) begin failures++; $display("FAIL hw_hwdata got=%h exp=%h", HWDATA, 32'h5678_5678); end
    @(negedge HCLK);
    checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin failures++; $display("FAIL hw_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    @(negedge HCLK);
  endtask

  task automatic test_error;
    drive_cmd(1'b1, 32'h4000_0010, 2'd2, 32'hCAFE_F00D);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL er_htrans1 got=%h exp=00", HTRANS); end
    HREADY = 1'b0; HRESP = 1'b1;
    @(negedge HCLK);
    checks++; if ({rsp_valid, HTRANS} !== 3'b000) begin failures++; $display("FAIL er_cycle1 got=%b exp=000", {rsp_valid, HTRANS}); end
    HREADY = 1'b1;
    @(negedge HCLK);
    HRESP = 1'b0;
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin failures++; $display("FAIL er_rsp got=%b exp=110", {rsp_valid, rsp_err, rsp_timeout}); end
    checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL er_htrans2 got=%h exp=00", HTRANS); end
    @(negedge HCLK);
    checks++; if ({rsp_valid, rsp_err} !== 2'b00) begin failures++; $display("FAIL er_clr got=%b exp=00", {rsp_valid, rsp_err}); end
  endtask

  task automatic test_size3_read;
    drive_cmd(1'b0, 32'h4000_0006, 2'd3, 32'h0);
    HRDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    checks++; if ({HADDR, HSIZE} !== {32'h4000_0004, 3'd2}) begin failures++; $display("FAIL s3_addr got=%h exp=%h", {HADDR, HSIZE}, {32'h4000_0004, 3'd2}); end
    @(negedge HCLK);
    @(negedge HCLK);
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL s3_rdata got=%h exp=%h", rsp_rdata, 32'hDEAD_BEEF); end
    @(negedge HCLK);
  endtask

  task automatic test_back_to_back;
    drive_cmd(1'b1, 32'h4000_0020, 2'd0, 32'h0000_00C3);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    checks++; if (HWDATA !== 32'hC3C3_C3C3) begin failures++; $display("FAIL bb_hwdata got=%h exp=%h", HWDATA, 32'hC3C3_C3C3); end
    @(negedge HCLK);
    checks++; if ({rsp_valid, cmd_ready} !== 2'b11) begin failures++; $display("FAIL bb_rsp1 got=%b exp=11", {rsp_valid, cmd_ready}); end
    drive_cmd(1'b0, 32'h4000_0002, 2'd1, 32'h0);
    HRDATA = 32'h9ABC_0000;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    checks++; if ({HTRANS, HADDR} !== {2'b10, 32'h4000_0002}) begin failures++; $display("FAIL bb_addr2 got=%h exp=%h", {HTRANS, HADDR}, {2'b10, 32'h4000_0002}); end
    @(negedge HCLK);
    @(negedge HCLK);
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0000_9ABC}) begin failures++; $display("FAIL bb_rsp2 got=%h exp=%h", {rsp_valid, rsp_rdata}, {1'b1, 32'h0000_9ABC}); end
    HRDATA = 32'h0;
    @(negedge HCLK);
  endtask

`ifdef AHBLITE_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    drive_cmd(1'b1, 32'h4000_0030, 2'd2, 32'h1111_2222);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    HREADY = 1'b0;
    repeat (3) @(negedge HCLK);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL to_early got=%h exp=0", rsp_valid); end
    @(negedge HCLK);
    checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111) begin failures++; $display("FAIL to_rsp got=%b exp=111", {rsp_valid, rsp_err, rsp_timeout}); end
    @(negedge HCLK);
    checks++; if ({cmd_ready, rsp_valid, rsp_timeout} !== 3'b100) begin failures++; $display("FAIL to_after got=%b exp=100", {cmd_ready, rsp_valid, rsp_timeout}); end
    HREADY = 1'b1;
    @(negedge HCLK);
  endtask
`endif

  task automatic test_reset_mid;
    drive_cmd(1'b0, 32'h4000_0040, 2'd2, 32'h0);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    HREADY = 1'b0;
    #2 HRESETn = 1'b0;
    #1;
    checks++; if ({HTRANS, cmd_ready, rsp_valid} !== 4'b0010) begin failures++; $display("FAIL rm_imm got=%b exp=0010", {HTRANS, cmd_ready, rsp_valid}); end
    checks++; if (HADDR !== 32'h0) begin failures++; $display("FAIL rm_haddr got=%h exp=0", HADDR); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    HREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      checks++; if ({rsp_valid, HTRANS, cmd_ready} !== 4'b0001) begin failures++; $display("FAIL rm_after%0d got=%b exp=0001", i, {rsp_valid, HTRANS, cmd_ready}); end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_size  = 2'd0;
    cmd_wdata = 32'h0;
    HREADY    = 1'b1;
    HRDATA    = 32'h0;
    HRESP     = 1'b0;
    test_reset;
    test_word_write;
    test_byte_read;
    test_half_write;
    test_error;
    test_size3_read;
    test_back_to_back;
`ifdef AHBLITE_MASTER_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
